// File: rtl/kfpga_config_pkg.sv
`default_nettype none
// ============================================================================
// Module   : kfpga_config_pkg
// Brief    : Shared types and default sizes for the routing-mux config chain
//            loader (also used by bitstream generation checks).
// Revision : 1.0 - initial release
// ============================================================================
package kfpga_config_pkg;

    // Default bitstream word size and chain length (8 muxes x 6 select bits)
    localparam int DEFAULT_WORD_WIDTH   = 8;
    localparam int DEFAULT_CHAIN_LENGTH = 48;

    // Loader sequencing states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_e;

    // Width of a down-counter that must hold the value n
    function automatic int count_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/config_word_serializer.sv
`default_nettype none
// ============================================================================
// Module   : config_word_serializer
// Brief    : Holds one bitstream word and shifts it LSB-first onto the chain;
//            generates in_ready so consecutive words stream without a bubble.
// Revision : 1.0 - initial release
// ============================================================================
module config_word_serializer
    import kfpga_config_pkg::*;
#(
    parameter int WORD_WIDTH = DEFAULT_WORD_WIDTH
) (
    input  logic                  clock_i,
    input  logic                  nreset_i,
    input  logic                  load_i,       // new load starting: flush word
    input  logic                  stop_i,       // final chain bit shifts now
    input  logic                  active_i,     // loader is in LOAD
    input  logic                  last_bit_i,   // next shift is the final chain bit
    input  logic [WORD_WIDTH-1:0] in_data_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    output logic                  config_enable_o,
    output logic                  config_out_o
);

    localparam int BL_W = count_width(WORD_WIDTH);
    localparam logic [BL_W-1:0] BL_FULL = BL_W'(WORD_WIDTH);
    localparam logic [BL_W-1:0] BL_ONE  = BL_W'(1);

    logic [WORD_WIDTH-1:0] shift_q, shift_d;
    logic [BL_W-1:0]       bits_left_q, bits_left_d;
    logic                  accept;

    // Handshake and chain drive, purely from registered state. A new word may
    // be taken while the last bit of the current one shifts, unless that bit
    // completes the chain.
    always_comb begin
        in_ready_o      = active_i &&
                          ((bits_left_q == '0) ||
                           ((bits_left_q == BL_ONE) && !last_bit_i));
        config_enable_o = active_i && (bits_left_q != '0);
        config_out_o    = active_i && shift_q[0];
        accept          = in_valid_i && in_ready_o;
    end

    // Next word/counter: accepting a word overrides the final decrement of the
    // previous one; completion discards whatever high bits remain.
    always_comb begin
        shift_d     = shift_q;
        bits_left_d = bits_left_q;
        if (load_i) begin
            shift_d     = '0;
            bits_left_d = '0;
        end else if (accept) begin
            shift_d     = in_data_i;
            bits_left_d = BL_FULL;
        end else if (stop_i) begin
            shift_d     = shift_q >> 1;
            bits_left_d = '0;
        end else if (config_enable_o) begin
            shift_d     = shift_q >> 1;
            bits_left_d = bits_left_q - BL_ONE;
        end
    end

    // Word and bit-count registers
    always_ff @(posedge clock_i or negedge nreset_i) begin
        if (!nreset_i) begin
            shift_q     <= '0;
            bits_left_q <= '0;
        end else begin
            shift_q     <= shift_d;
            bits_left_q <= bits_left_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/config_chain_loader.sv
`default_nettype none
// ============================================================================
// Module   : config_chain_loader
// Brief    : Sequences a full load of the routing-mux configuration scan
//            chain from a valid/ready bitstream word stream, counting exactly
//            CHAIN_LENGTH shifts before flagging completion.
// Revision : 1.0 - initial release
// ============================================================================
module config_chain_loader
    import kfpga_config_pkg::*;
#(
    parameter int WORD_WIDTH   = DEFAULT_WORD_WIDTH,
    parameter int CHAIN_LENGTH = DEFAULT_CHAIN_LENGTH,
    parameter int COUNT_WIDTH  = $clog2(CHAIN_LENGTH + 1)
) (
    input  logic                  clock_i,
    input  logic                  nreset_i,
    input  logic                  start_i,
    input  logic [WORD_WIDTH-1:0] in_data_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    output logic                  config_out_o,
    output logic                  config_enable_o,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam logic [COUNT_WIDTH-1:0] LAST_COUNT = COUNT_WIDTH'(CHAIN_LENGTH - 1);
    localparam logic [COUNT_WIDTH-1:0] COUNT_ONE  = COUNT_WIDTH'(1);

    state_e                 state_q;
    logic [COUNT_WIDTH-1:0] chain_count_q;
    logic                   busy_q;
    logic                   done_q;

    logic w_load;
    logic w_active;
    logic w_last_bit;
    logic w_stop;
    logic w_shift;

    // Control strobes for the serializer; start is only honoured outside LOAD
    always_comb begin
        w_active   = (state_q == LOAD);
        w_load     = start_i && (state_q != LOAD);
        w_last_bit = (chain_count_q == LAST_COUNT);
        w_stop     = w_shift && w_last_bit;
    end

    config_word_serializer #(
        .WORD_WIDTH (WORD_WIDTH)
    ) u_serializer (
        .clock_i         (clock_i),
        .nreset_i        (nreset_i),
        .load_i          (w_load),
        .stop_i          (w_stop),
        .active_i        (w_active),
        .last_bit_i      (w_last_bit),
        .in_data_i       (in_data_i),
        .in_valid_i      (in_valid_i),
        .in_ready_o      (in_ready_o),
        .config_enable_o (w_shift),
        .config_out_o    (config_out_o)
    );

    // Load sequencer: counts shifted bits and holds done until the next start
    always_ff @(posedge clock_i or negedge nreset_i) begin
        if (!nreset_i) begin
            state_q       <= IDLE;
            chain_count_q <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start_i) begin
                        state_q       <= LOAD;
                        chain_count_q <= '0;
                        busy_q        <= 1'b1;
                        done_q        <= 1'b0;
                    end
                end
                LOAD: begin
                    if (w_shift) begin
                        chain_count_q <= chain_count_q + COUNT_ONE;
                        if (w_last_bit) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign config_enable_o = w_shift;
    assign busy_o          = busy_q;
    assign done_o          = done_q;

endmodule
`default_nettype wire

// File: tb/tb_config_chain_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_config_chain_loader
// Brief    : Directed, table-driven bench for config_chain_loader. Instance A
//            uses the default 48-bit chain, instance B a 20-bit chain.
// Revision : 1.0 - initial release
// ============================================================================
module tb_config_chain_loader;

    typedef struct {
        int          k;          // 0 = 48-bit chain, 1 = 20-bit chain
        logic [47:0] words;      // word i in bits [8i+7:8i]
        int          nw;
        int          gap;        // idle cycles inserted once in_ready rises
        bit          mid_start;  // pulse start while loading the third word
        int          exp_cnt;
        logic [63:0] exp_pat;    // chain bit i = i-th shifted bit
        int          exp_bub;    // busy cycles without a shift
    } rec_t;

    logic       clk = 1'b0;
    logic       nreset = 1'b0;
    logic [1:0] start_s = '0;
    logic [1:0] valid_s = '0;
    logic [7:0] data_s [2];
    logic [1:0] rdy_w, en_w, out_w, busy_w, done_w;

    int n_pass = 0;
    int n_tot  = 0;

    // monitor state, written only by the monitor process
    int          cyc [2];
    int          en_cnt [2];
    int          bub [2];
    int          last_en [2];
    int          done_cyc [2];
    int          seen_id [2];
    logic [63:0] cap [2];
    bit          rdy_late [2];
    bit          done_prev [2];
    // written only by the stimulus process
    int          run_id [2];
    bit          words_done [2];

    rec_t tbl [5];

    always #5 clk = ~clk;

    config_chain_loader #(.WORD_WIDTH(8), .CHAIN_LENGTH(48)) u_dut_a (
        .clock_i         (clk),
        .nreset_i        (nreset),
        .start_i         (start_s[0]),
        .in_data_i       (data_s[0]),
        .in_valid_i      (valid_s[0]),
        .in_ready_o      (rdy_w[0]),
        .config_out_o    (out_w[0]),
        .config_enable_o (en_w[0]),
        .busy_o          (busy_w[0]),
        .done_o          (done_w[0])
    );

    config_chain_loader #(.WORD_WIDTH(8), .CHAIN_LENGTH(20)) u_dut_b (
        .clock_i         (clk),
        .nreset_i        (nreset),
        .start_i         (start_s[1]),
        .in_data_i       (data_s[1]),
        .in_valid_i      (valid_s[1]),
        .in_ready_o      (rdy_w[1]),
        .config_out_o    (out_w[1]),
        .config_enable_o (en_w[1]),
        .busy_o          (busy_w[1]),
        .done_o          (done_w[1])
    );

    // Chain-side monitor: records every shifted bit and handshake timing
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            cyc[k]++;
            if (seen_id[k] != run_id[k]) begin
                seen_id[k]  = run_id[k];
                en_cnt[k]   = 0;
                bub[k]      = 0;
                last_en[k]  = 0;
                done_cyc[k] = 0;
                cap[k]      = '0;
                rdy_late[k] = 1'b0;
            end
            if (en_w[k]) begin
                if (en_cnt[k] < 64) cap[k][en_cnt[k]] = out_w[k];
                en_cnt[k]++;
                last_en[k] = cyc[k];
            end else if (busy_w[k]) begin
                bub[k]++;
            end
            if (done_w[k] && !done_prev[k] && done_cyc[k] == 0) done_cyc[k] = cyc[k];
            done_prev[k] = done_w[k];
            if (words_done[k] && rdy_w[k]) rdy_late[k] = 1'b1;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    task automatic wait_rdy(input int k, inout int to);
        int t = 0;
        while (!rdy_w[k] && t < 200) begin
            @(negedge clk);
            start_s[k] = 1'b0;
            t++;
        end
        if (t >= 200) to++;
    endtask

    task automatic run_load(input int k, input logic [47:0] words, input int nw,
                            input int gap, input bit mid, output int to);
        int t;
        to = 0;
        @(posedge clk);
        #1 run_id[k]++;
        @(negedge clk);
        start_s[k] = 1'b1;
        @(negedge clk);
        start_s[k] = 1'b0;
        for (int i = 0; i < nw; i++) begin
            data_s[k]  = words[8*i +: 8];
            valid_s[k] = 1'b1;
            if (mid && i == 2) start_s[k] = 1'b1;
            wait_rdy(k, to);
            @(negedge clk);
            start_s[k] = 1'b0;
            if (i == nw - 1) begin
                valid_s[k]    = 1'b0;
                words_done[k] = 1'b1;
            end else if (gap > 0) begin
                valid_s[k] = 1'b0;
                wait_rdy(k, to);
                repeat (gap) @(negedge clk);
            end
        end
        t = 0;
        while (!done_w[k] && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) to++;
        repeat (3) @(negedge clk);
        words_done[k] = 1'b0;
    endtask

    task automatic do_checks(input int k, input int exp_cnt, input logic [63:0] exp_pat,
                             input int exp_bub, input int to);
        chk("handshake_timeout", 64'(to), 64'd0);
        chk("enable_count", 64'(en_cnt[k]), 64'(exp_cnt));
        chk("chain_pattern", cap[k], exp_pat);
        chk("bubble_cycles", 64'(bub[k]), 64'(exp_bub));
        chk("done_latency", 64'(done_cyc[k]), 64'(last_en[k] + 1));
        chk("ready_after_last_word", 64'(rdy_late[k]), 64'd0);
        chk("end_flags_busy_done_rdy_en",
            64'({busy_w[k], done_w[k], rdy_w[k], en_w[k]}), 64'b0100);
    endtask

    initial begin
        int to;
        int t;

        tbl[0] = '{0, 48'h201008040201, 6, 0, 1'b0, 48, 64'h201008040201, 1};
        tbl[1] = '{0, 48'h201008040201, 6, 3, 1'b0, 48, 64'h201008040201, 16};
        tbl[2] = '{0, 48'h7E8100FF3CA5, 6, 0, 1'b1, 48, 64'h7E8100FF3CA5, 1};
        tbl[3] = '{1, 48'h000000AB00FF, 3, 0, 1'b0, 20, 64'h00000000000B00FF, 1};
        tbl[4] = '{0, 48'h123456789ABC, 6, 1, 1'b0, 48, 64'h123456789ABC, 6};

        // reset, then idle with in_valid driven into A: everything stays 0
        data_s[0]  = 8'hFF;
        data_s[1]  = 8'h00;
        valid_s[0] = 1'b1;
        repeat (3) @(negedge clk);
        nreset = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++)
                chk("idle_outputs", 64'({rdy_w[k], en_w[k], out_w[k], busy_w[k], done_w[k]}), 64'd0);
        end
        valid_s[0] = 1'b0;

        // table-driven full loads
        for (int r = 0; r < 5; r++) begin
            run_load(tbl[r].k, tbl[r].words, tbl[r].nw, tbl[r].gap, tbl[r].mid_start, to);
            do_checks(tbl[r].k, tbl[r].exp_cnt, tbl[r].exp_pat, tbl[r].exp_bub, to);
        end

        // in DONE: offered words are ignored, done holds
        data_s[0]  = 8'hA5;
        valid_s[0] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("done_ignores_valid", 64'({rdy_w[0], en_w[0], busy_w[0], done_w[0]}), 64'b0001);
        end
        valid_s[0] = 1'b0;
        @(negedge clk);
        start_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0;
        chk("restart_from_done", 64'({done_w[0], busy_w[0]}), 64'b01);

        // asynchronous reset in the middle of a load
        @(posedge clk);
        #1 run_id[0]++;
        @(negedge clk);
        data_s[0]  = 8'hFF;
        valid_s[0] = 1'b1;
        t = 0;
        while (en_cnt[0] < 13 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("reach_13_shifts_timeout", 64'(t >= 200), 64'd0);
        #2 nreset = 1'b0;
        #1;
        chk("async_reset_a", 64'({rdy_w[0], en_w[0], out_w[0], busy_w[0], done_w[0]}), 64'd0);
        chk("async_reset_b", 64'({rdy_w[1], en_w[1], out_w[1], busy_w[1], done_w[1]}), 64'd0);
        valid_s[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        nreset = 1'b1;
        @(negedge clk);
        chk("post_reset_idle", 64'({rdy_w[0], en_w[0], out_w[0], busy_w[0], done_w[0]}), 64'd0);
        run_load(0, 48'h201008040201, 6, 0, 1'b0, to);
        do_checks(0, 48, 64'h201008040201, 1, to);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_tot);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/config_chain_loader.md
Name: config_chain_loader

Overview:
- Sequences the serial configuration scan chain that feeds the routing multiplexers' selector registers (switch-box/input-connect muxes, 6 select bits each).
- Accepts bitstream words from the bitstream port over a valid/ready handshake and serialises them LSB-first onto the chain, driving the chain shift enable.
- Counts exactly CHAIN_LENGTH shifted bits, then flags completion.
- Sits between the top-level bitstream interface and the tile config chain.

Parameters:
- WORD_WIDTH, 8, bits per incoming bitstream word.
- CHAIN_LENGTH, 48, total config bits in the chain (8 muxes x 6 select bits); must be >= 1.
- COUNT_WIDTH, $clog2(CHAIN_LENGTH+1), width of the shifted-bit counter.

Ports:
- clock  input  1  single clock for all state.
- nreset  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; begins a new load when not busy.
- in_data  input  WORD_WIDTH  bitstream word; bit 0 is shifted first.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader accepts in_data this cycle.
- config_out  output  1  serial config bit to the chain head.
- config_enable  output  1  chain shift enable; the chain samples config_out on clock when high.
- busy  output  1  load in progress.
- done  output  1  full chain loaded; held until the next accepted start.

Behaviour:
- Reset (nreset low, asynchronous):
  - state=IDLE; shift register, bits_left and chain_count all 0.
  - in_ready=0, config_enable=0, config_out=0, busy=0, done=0.
  - Reset mid-load abandons the load. No partial-done indication. The chain contents are undefined until the next full load.
- State IDLE:
  - start=1 -> LOAD; chain_count=0, bits_left=0, done cleared on the same edge.
- State LOAD:
  - busy=1.
  - config_enable = (bits_left != 0), combinational from registered state.
  - config_out = shift_reg[0].
- Shift cycle (config_enable=1), on the clock edge:
  - shift_reg >>= 1, bits_left -= 1, chain_count += 1.
- in_ready = LOAD and (bits_left==0 or (bits_left==1 and chain_count != CHAIN_LENGTH-1)).
  - Result: back-to-back words stream with no bubble (full throughput, one bit per cycle).
- Word accept (in_valid and in_ready), on the edge:
  - shift_reg <= in_data, bits_left <= WORD_WIDTH.
  - This overrides the decrement when the last bit of the previous word shifts on the same edge.
  - The first bit of the accepted word appears on config_out with config_enable=1 in the next cycle.
- Completion: a shift cycle with chain_count==CHAIN_LENGTH-1 ->
  - DONE on that edge; bits_left cleared.
  - Remaining high bits of the final word are discarded (CHAIN_LENGTH not a multiple of WORD_WIDTH).
- Underflow: in_valid low with bits_left==0 -> config_enable=0 and the chain holds. There is no timeout.
- State DONE:
  - done=1, busy=0, in_ready=0, config_enable=0.
  - start=1 -> LOAD (reload), done cleared.
- start during LOAD is ignored.
- in_data/in_valid outside LOAD are ignored (in_ready=0).
- Exactly CHAIN_LENGTH config_enable cycles occur per completed load. Never more.

Decomposition:
- Package kfpga_config_pkg:
  - state enum {IDLE, LOAD, DONE}.
  - Default WORD_WIDTH/CHAIN_LENGTH constants, shared with bitstream generation checks.
- One natural sub-module: config_word_serializer.
  - Contents: shift register, bits_left counter, in_ready/config_enable/config_out logic.
  - Controls: load and stop inputs.
- The top holds the FSM and chain_count.

Test Plan:
- Defaults; start, then 6 words 0x01,0x02,0x04,0x08,0x10,0x20 with in_valid held high -> 48 consecutive config_enable cycles; config_out has 1s at chain bit indices 0,9,18,27,36,45; done=1 the cycle after the 48th shift; in_ready=0 after word 6.
- in_valid deasserted 3 cycles between each word -> config_enable drops exactly during the gaps; total enable cycles 48; same bit sequence; done asserted.
- CHAIN_LENGTH=20 override, words 0xFF,0x00,0xAB -> 20 shifts; last 4 bits are 0xB LSB-first (1,1,0,1); 0xA discarded; in_ready never high after the third word; done=1.
- Assert nreset after 13 shifts -> all outputs 0 immediately (asynchronously); a new start then loads a full 48 bits from chain_count 0.
- start pulsed mid-load and in_valid driven in IDLE/DONE -> no effect, no extra config_enable; start in DONE restarts with done=0 the next cycle.
- Reset values: after nreset release with no start -> in_ready, config_enable, config_out, busy and done all 0 for 10 cycles.
